bus_sequencer: RTL and testbench

BUS_SEQUENCER -- requirements
Module: bus_sequencer

---
 rtl/bus_seq_pkg.sv | 32 +++
 rtl/bus_sequencer_if.sv | 33 +++
 rtl/bus_seq_decode.sv | 23 ++
 rtl/bus_sequencer.sv | 147 ++++++++++++++
 tb/tb_bus_sequencer.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_seq_pkg.sv
// Shared types and constants for the bus sequencer: FSM states, bus mux
// source codes and the recognised opcodes.
package bus_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    T0,
    T1,
    T2,
    T3,
    T4,
    T5,
    HALT
  } state_t;

  localparam logic [4:0] SEL_R0      = 5'd0;   // r0-r15 occupy codes 0-15
  localparam logic [4:0] SEL_HI      = 5'd16;
  localparam logic [4:0] SEL_LO      = 5'd17;
  localparam logic [4:0] SEL_ZHI     = 5'd18;
  localparam logic [4:0] SEL_ZLO     = 5'd19;
  localparam logic [4:0] SEL_PC      = 5'd20;
  localparam logic [4:0] SEL_MDR     = 5'd21;
  localparam logic [4:0] SEL_INPORT  = 5'd22;
  localparam logic [4:0] SEL_C       = 5'd23;
  localparam logic [4:0] IDLE_SEL_DEF = 5'd31;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;

endpackage

// File: rtl/bus_sequencer_if.sv
// Control/status bundle between the sequencer (master) and the datapath (slave).
interface bus_sequencer_if;
  logic        run;
  logic        stop;
  logic [31:0] ir;
  logic        mem_ready;
  logic [4:0]  bus_sel;
  logic [15:0] reg_in;
  logic        pc_in;
  logic        ir_in;
  logic        mar_in;
  logic        mdr_in;
  logic        y_in;
  logic        z_in;
  logic        inc_pc;
  logic        mem_read;
  logic [4:0]  alu_op;
  logic        busy;
  logic        done;
  logic        illegal;

  modport master (
    input  run, stop, ir, mem_ready,
    output bus_sel, reg_in, pc_in, ir_in, mar_in, mdr_in, y_in, z_in,
           inc_pc, mem_read, alu_op, busy, done, illegal
  );

  modport slave (
    output run, stop, ir, mem_ready,
    input  bus_sel, reg_in, pc_in, ir_in, mar_in, mdr_in, y_in, z_in,
           inc_pc, mem_read, alu_op, busy, done, illegal
  );
endinterface

// File: rtl/bus_seq_decode.sv
// Instruction field extraction and opcode legality check (purely combinational).
module bus_seq_decode
  import bus_seq_pkg::*;
(
  input  logic [31:0] ir,
  output logic [4:0]  opcode,
  output logic [3:0]  ra,
  output logic [3:0]  rb,
  output logic [3:0]  rc,
  output logic        legal
);

  logic ir_lsbs_unused;

  assign opcode = ir[31:27];
  assign ra     = ir[26:23];
  assign rb     = ir[22:19];
  assign rc     = ir[18:15];
  assign legal  = opcode inside {OP_ADD, OP_SUB, OP_AND, OP_OR};

  assign ir_lsbs_unused = ^ir[14:0];

endmodule

// File: rtl/bus_sequencer.sv
// Instruction sequencer for a single-bus datapath: fetch in T0-T2, execute in T3-T5.
// Build option BUS_SEQ_MEM_WAIT_EN: T1 stalls until mem_ready; otherwise T1 is one cycle.
module bus_sequencer
  import bus_seq_pkg::*;
#(
  parameter logic [4:0] IDLE_SEL = IDLE_SEL_DEF
) (
  input logic             clock,
  input logic             clear,
  bus_sequencer_if.master bus
);

  // state | meaning
  // IDLE  | waiting for run without stop
  // T0    | PC -> MAR, PC increment, Z captures
  // T1    | memory read into MDR, PC loaded from ZLo on entry
  // T2    | MDR -> IR, opcode legality check
  // T3    | Rb -> Y
  // T4    | Rc through ALU, result into Z
  // T5    | ZLo -> Ra, completion pulse
  // HALT  | illegal opcode seen, held until clear

  state_t      state, state_nxt;
  logic        t1_wait;
  logic        mem_ok;
  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc;
  logic        legal;

  logic [4:0]  bus_sel;
  logic [15:0] reg_in;
  logic        pc_in, ir_in, mar_in, mdr_in, y_in, z_in, inc_pc, mem_read;
  logic [4:0]  alu_op;
  logic        busy, done, illegal;

  bus_seq_decode u_decode (
    .ir     (bus.ir),
    .opcode (opcode),
    .ra     (ra),
    .rb     (rb),
    .rc     (rc),
    .legal  (legal)
  );

`ifdef BUS_SEQ_MEM_WAIT_EN
  assign mem_ok = bus.mem_ready;
`else
  logic mem_ready_unused;
  assign mem_ok           = 1'b1;
  assign mem_ready_unused = bus.mem_ready;
`endif

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state   <= IDLE;
      t1_wait <= 1'b0;
    end else begin
      state   <= state_nxt;
      t1_wait <= (state == T1) && (state_nxt == T1);
    end
  end

  always_comb begin
    state_nxt = state;
    bus_sel   = IDLE_SEL;
    reg_in    = '0;
    pc_in     = 1'b0;
    ir_in     = 1'b0;
    mar_in    = 1'b0;
    mdr_in    = 1'b0;
    y_in      = 1'b0;
    z_in      = 1'b0;
    inc_pc    = 1'b0;
    mem_read  = 1'b0;
    alu_op    = '0;
    busy      = 1'b0;
    done      = 1'b0;
    illegal   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.run && !bus.stop) state_nxt = T0;
      end
      T0: begin
        busy      = 1'b1;
        bus_sel   = SEL_PC;
        mar_in    = 1'b1;
        inc_pc    = 1'b1;
        z_in      = 1'b1;
        state_nxt = T1;
      end
      T1: begin
        busy     = 1'b1;
        bus_sel  = SEL_ZLO;
        pc_in    = !t1_wait;   // PC reload only once, even across a stall
        mem_read = 1'b1;
        mdr_in   = 1'b1;
        if (mem_ok) state_nxt = T2;
      end
      T2: begin
        busy      = 1'b1;
        bus_sel   = SEL_MDR;
        ir_in     = 1'b1;
        state_nxt = legal ? T3 : HALT;
      end
      T3: begin
        busy      = 1'b1;
        bus_sel   = {1'b0, rb};
        y_in      = 1'b1;
        state_nxt = T4;
      end
      T4: begin
        busy      = 1'b1;
        bus_sel   = {1'b0, rc};
        alu_op    = opcode;
        z_in      = 1'b1;
        state_nxt = T5;
      end
      T5: begin
        busy      = 1'b1;
        bus_sel   = SEL_ZLO;
        reg_in    = 16'(1) << ra;
        done      = 1'b1;
        state_nxt = (bus.run && !bus.stop) ? T0 : IDLE;
      end
      HALT: begin
        illegal = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.bus_sel  = bus_sel;
  assign bus.reg_in   = reg_in;
  assign bus.pc_in    = pc_in;
  assign bus.ir_in    = ir_in;
  assign bus.mar_in   = mar_in;
  assign bus.mdr_in   = mdr_in;
  assign bus.y_in     = y_in;
  assign bus.z_in     = z_in;
  assign bus.inc_pc   = inc_pc;
  assign bus.mem_read = mem_read;
  assign bus.alu_op   = alu_op;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.illegal  = illegal;

endmodule

// File: tb/tb_bus_sequencer.sv
// Self-checking bench for bus_sequencer: expected per-cycle output vectors are
// generated from the instruction-level behaviour and compared cycle by cycle.
module tb_bus_sequencer;

  typedef struct packed {
    logic [4:0]  sel;
    logic [15:0] reg_in;
    logic        pc_in, ir_in, mar_in, mdr_in, y_in, z_in, inc_pc, mem_read;
    logic [4:0]  alu_op;
    logic        busy, done, illegal;
  } vec_t;

`ifdef BUS_SEQ_MEM_WAIT_EN
  localparam bit MEM_WAIT = 1'b1;
`else
  localparam bit MEM_WAIT = 1'b0;
`endif

  logic clock = 1'b0;
  logic clear = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  vec_t        exp_q[$];
  vec_t        obs_q[$];
  logic [31:0] ir_q[$];
  int          wait_q[$];

  bus_sequencer_if bus();

  bus_sequencer #(.IDLE_SEL(5'd31)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic vec_t observe();
    vec_t v;
    v.sel      = bus.bus_sel;
    v.reg_in   = bus.reg_in;
    v.pc_in    = bus.pc_in;
    v.ir_in    = bus.ir_in;
    v.mar_in   = bus.mar_in;
    v.mdr_in   = bus.mdr_in;
    v.y_in     = bus.y_in;
    v.z_in     = bus.z_in;
    v.inc_pc   = bus.inc_pc;
    v.mem_read = bus.mem_read;
    v.alu_op   = bus.alu_op;
    v.busy     = bus.busy;
    v.done     = bus.done;
    v.illegal  = bus.illegal;
    return v;
  endfunction

  function automatic vec_t idle_vec(input bit halted);
    vec_t v = '0;
    v.sel     = 5'd31;
    v.illegal = halted;
    return v;
  endfunction

  // Appends the cycle-by-cycle outputs of one instruction; returns 0 if it halts.
  function automatic bit model_instr(input logic [31:0] ir, input int nwait);
    vec_t v;
    logic [4:0] opc = ir[31:27];
    logic [3:0] ra = ir[26:23];
    logic [3:0] rb = ir[22:19];
    logic [3:0] rc = ir[18:15];
    int t1_len = MEM_WAIT ? nwait + 1 : 1;
    v = '0; v.busy = 1; v.sel = 5'd20; v.mar_in = 1; v.inc_pc = 1; v.z_in = 1;
    exp_q.push_back(v);
    for (int i = 0; i < t1_len; i++) begin
      v = '0; v.busy = 1; v.sel = 5'd19; v.mem_read = 1; v.mdr_in = 1; v.pc_in = (i == 0);
      exp_q.push_back(v);
    end
    v = '0; v.busy = 1; v.sel = 5'd21; v.ir_in = 1;
    exp_q.push_back(v);
    if (opc > 5'd3) begin
      exp_q.push_back(idle_vec(1'b1));
      return 1'b0;
    end
    v = '0; v.busy = 1; v.sel = {1'b0, rb}; v.y_in = 1;
    exp_q.push_back(v);
    v = '0; v.busy = 1; v.sel = {1'b0, rc}; v.alu_op = opc; v.z_in = 1;
    exp_q.push_back(v);
    v = '0; v.busy = 1; v.sel = 5'd19; v.reg_in = 16'h0001 << ra; v.done = 1;
    exp_q.push_back(v);
    return 1'b1;
  endfunction

  function automatic void build_exp();
    bit ok = 1'b1;
    exp_q.delete();
    for (int i = 0; i < ir_q.size(); i++)
      if (ok) ok = model_instr(ir_q[i], wait_q[i]);
    if (ok) exp_q.push_back(idle_vec(1'b0));
    else begin
      exp_q.push_back(idle_vec(1'b1));
      exp_q.push_back(idle_vec(1'b1));
    end
  endfunction

  function automatic logic [31:0] rand_ir(input logic [4:0] opc);
    logic [31:0] r = $urandom();
    return {opc, r[26:0]};
  endfunction

  // Runs ir_q from IDLE for exactly exp_q.size() cycles, recording outputs.
  task automatic drive_seq(input bit stop_at_t3, input bit end_run);
    int idx = 0;
    int wcnt = 0;
    vec_t v;
    obs_q.delete();
    bus.ir = ir_q[0];
    bus.run = 1'b1;
    bus.stop = 1'b0;
    for (int c = 0; c < exp_q.size(); c++) begin
      @(posedge clock); #1;
      v = observe();
      obs_q.push_back(v);
      if (v.mar_in) wcnt = 0;
      if (v.mem_read && idx < wait_q.size()) begin
        if (wcnt < wait_q[idx]) begin
          bus.mem_ready = 1'b0;
          wcnt++;
        end else bus.mem_ready = 1'b1;
      end else bus.mem_ready = 1'($urandom_range(0, 1));
      if (stop_at_t3 && v.y_in) begin
        bus.run = 1'b1;
        bus.stop = 1'b1;
      end
      if (v.done) begin
        idx++;
        if (idx < ir_q.size()) bus.ir = ir_q[idx];
        else bus.run = end_run;
      end
    end
  endtask

  task automatic pulse_clear();
    bus.run = 1'b0;
    bus.stop = 1'b0;
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    vec_t v;
    #2;
    v = observe();
    vectors++;
    if (v !== idle_vec(1'b0)) begin
      miscompares++;
      $display("FAIL reset_asserted: got %h want %h", v, idle_vec(1'b0));
    end
    @(posedge clock); #1;
    clear = 1'b0;
    @(posedge clock); #1;
    v = observe();
    vectors++;
    if (v !== idle_vec(1'b0)) begin
      miscompares++;
      $display("FAIL reset_released_idle: got %h want %h", v, idle_vec(1'b0));
    end
  endtask

  task automatic test_add();
    int ndone = 0;
    ir_q = '{32'h01908000};
    wait_q = '{0};
    build_exp();
    drive_seq(1'b0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL add[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
      if (obs_q[i].done) ndone++;
    end
    vectors++;
    if (ndone != 1) begin
      miscompares++;
      $display("FAIL add_done_count: got %0d want 1", ndone);
    end
  endtask

  task automatic test_mem_wait();
    int npc = 0;
    int nrd = 0;
    ir_q = '{rand_ir(5'd2)};
    wait_q = '{3};
    build_exp();
    drive_seq(1'b0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL mem_wait[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
      if (obs_q[i].pc_in) npc++;
      if (obs_q[i].mem_read) nrd++;
    end
    vectors++;
    if (npc != 1 || nrd != (MEM_WAIT ? 4 : 1)) begin
      miscompares++;
      $display("FAIL mem_wait_t1_len: got pc_in=%0d t1=%0d want pc_in=1 t1=%0d",
               npc, nrd, MEM_WAIT ? 4 : 1);
    end
  endtask

  task automatic test_illegal();
    vec_t v;
    ir_q = '{rand_ir(5'd9)};
    wait_q = '{0};
    build_exp();
    drive_seq(1'b0, 1'b1);
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL illegal[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    bus.run = 1'b0;
    clear = 1'b1;
    #1;
    v = observe();
    vectors++;
    if (v !== idle_vec(1'b0)) begin
      miscompares++;
      $display("FAIL illegal_clear: got %h want %h", v, idle_vec(1'b0));
    end
    @(posedge clock); #1;
    clear = 1'b0;
    @(posedge clock); #1;
    v = observe();
    vectors++;
    if (v !== idle_vec(1'b0)) begin
      miscompares++;
      $display("FAIL illegal_after_clear: got %h want %h", v, idle_vec(1'b0));
    end
  endtask

  task automatic test_stop_override();
    ir_q = '{rand_ir(5'd3)};
    wait_q = '{1};
    build_exp();
    drive_seq(1'b1, 1'b1);
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL stop_override[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    bus.run = 1'b0;
    bus.stop = 1'b0;
  endtask

  task automatic test_back_to_back();
    int first = -1;
    int second = -1;
    ir_q = '{rand_ir(5'd1), rand_ir(5'd1)};
    wait_q = '{0, 0};
    build_exp();
    drive_seq(1'b0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
      if (obs_q[i].done) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    vectors++;
    if (first < 0 || second - first != 6) begin
      miscompares++;
      $display("FAIL back_to_back_spacing: got %0d want 6", second - first);
    end
  endtask

  task automatic test_clear_mid();
    vec_t v;
    bit found = 1'b0;
    bus.ir = rand_ir(5'd0);
    bus.run = 1'b1;
    bus.stop = 1'b0;
    bus.mem_ready = 1'b1;
    for (int c = 0; c < 20 && !found; c++) begin
      @(posedge clock); #1;
      v = observe();
      if (v.z_in && !v.mar_in) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL clear_mid_reach_t4: got no T4 within 20 cycles want T4");
    end
    #2;
    clear = 1'b1;
    #1;
    v = observe();
    vectors++;
    if (v !== idle_vec(1'b0)) begin
      miscompares++;
      $display("FAIL clear_mid_async: got %h want %h", v, idle_vec(1'b0));
    end
    bus.run = 1'b0;
    @(posedge clock); #1;
    v = observe();
    vectors++;
    if (v.sel !== 5'd31 || v.reg_in !== 16'h0 || v.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_mid_next: got sel=%0d reg_in=%h busy=%b want sel=31 reg_in=0000 busy=0",
               v.sel, v.reg_in, v.busy);
    end
    clear = 1'b0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 16; it++) begin
      int n = $urandom_range(1, 3);
      bit bad_last = ($urandom_range(0, 4) == 0);
      ir_q.delete();
      wait_q.delete();
      for (int k = 0; k < n; k++) begin
        if (bad_last && k == n - 1) ir_q.push_back(rand_ir(5'($urandom_range(4, 31))));
        else ir_q.push_back(rand_ir(5'($urandom_range(0, 3))));
        wait_q.push_back($urandom_range(0, 3));
      end
      build_exp();
      drive_seq(1'b0, 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (obs_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL random_it%0d[%0d]: got %h want %h", it, i, obs_q[i], exp_q[i]);
        end
      end
      if (bad_last) pulse_clear();
      bus.run = 1'b0;
      bus.stop = 1'b0;
    end
  endtask

  initial begin
    bus.run = 1'b0;
    bus.stop = 1'b0;
    bus.ir = '0;
    bus.mem_ready = 1'b0;
    test_reset();
    test_add();
    test_mem_wait();
    test_illegal();
    test_stop_override();
    test_back_to_back();
    test_clear_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500000 want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
